// File: rtl/multicycle_main_fsm_if.sv
// multicycle_main_fsm_if: opcode/memory-ready inputs and datapath control outputs of the main FSM.
interface multicycle_main_fsm_if;
  logic [6:0] Op;
  logic       MemReady;
  logic       PCUpdate, Branch, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic       Illegal, Timeout;
  logic [4:0] State;
  modport master (
    input  Op, MemReady,
    output PCUpdate, Branch, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal, Timeout, State
  );
  modport slave (
    output Op, MemReady,
    input  PCUpdate, Branch, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal, Timeout, State
  );
endinterface

// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm: multi-cycle RV32I control sequencer with bounded memory waits and sticky traps.
// Define MCFSM_UIMM_EN to build the LUI/AUIPC states; otherwise those opcodes trap as illegal.
module multicycle_main_fsm #(
  parameter int MEM_TIMEOUT = 16
) (
  input logic clk,
  input logic rst_n,
  multicycle_main_fsm_if.master bus
);
  localparam int CW = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WMAX = MEM_TIMEOUT > 0 ? CW'(MEM_TIMEOUT) : '1;
`ifdef MCFSM_UIMM_EN
  localparam bit UIMM = 1'b1;
`else
  localparam bit UIMM = 1'b0;
`endif
  typedef enum logic [4:0] {
    FETCH = 5'd0, DECODE = 5'd1, MEMADR = 5'd2, MEMREAD = 5'd3, MEMWB = 5'd4,
    MEMWRITE = 5'd5, EXECR = 5'd6, EXECI = 5'd7, ALUWB = 5'd8, BEQ = 5'd9,
    JAL = 5'd10, JALR = 5'd11, JALRLINK = 5'd12,
`ifdef MCFSM_UIMM_EN
    LUI = 5'd13, AUIPC = 5'd14,
`endif
    TRAP = 5'd15
  } state_e;
  state_e state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic illegal_q, illegal_d, timeout_q, timeout_d, mem_wait;
  logic [6:0] op;
  assign op = bus.Op;
  assign bus.State = state_q;
  assign bus.Illegal = illegal_q;
  assign bus.Timeout = timeout_q;
  assign bus.ImmSrc = op == 7'b0100011 ? 3'b001 :
                      op == 7'b1100011 ? 3'b010 :
                      op == 7'b1101111 ? 3'b011 :
                      UIMM && (op == 7'b0110111 || op == 7'b0010111) ? 3'b100 : 3'b000;
  assign mem_wait = (state_q == FETCH || state_q == MEMREAD || state_q == MEMWRITE) && !bus.MemReady;
  always_comb begin
    state_d = state_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    bus.PCUpdate = 1'b0;
    bus.Branch = 1'b0;
    bus.AdrSrc = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ResultSrc = 2'b00;
    bus.ALUSrcA = 2'b00;
    bus.ALUSrcB = 2'b00;
    bus.ALUOp = 2'b00;
    case (state_q)
      FETCH: begin
        bus.ALUSrcB = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite = bus.MemReady & rst_n;
        bus.PCUpdate = bus.MemReady & rst_n;
        state_d = bus.MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: state_d = MEMADR;
          7'b0110011: state_d = EXECR;
          7'b0010011: state_d = EXECI;
          7'b1100011: state_d = BEQ;
          7'b1101111: state_d = JAL;
          7'b1100111: state_d = JALR;
`ifdef MCFSM_UIMM_EN
          7'b0110111: state_d = LUI;
          7'b0010111: state_d = AUIPC;
`endif
          default: begin
            state_d = TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        state_d = op == 7'b0000011 ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        bus.AdrSrc = 1'b1;
        state_d = bus.MemReady ? MEMWB : MEMREAD;
      end
      MEMWRITE: begin
        bus.AdrSrc = 1'b1;
        bus.MemWrite = 1'b1;
        state_d = bus.MemReady ? FETCH : MEMWRITE;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite = 1'b1;
        state_d = FETCH;
      end
      EXECR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUOp = 2'b10;
        state_d = ALUWB;
      end
      EXECI: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        bus.ALUOp = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        bus.RegWrite = 1'b1;
        state_d = FETCH;
      end
      BEQ: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUOp = 2'b01;
        bus.Branch = 1'b1;
        state_d = FETCH;
      end
      JAL: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.PCUpdate = 1'b1;
        state_d = ALUWB;
      end
      JALR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        bus.ResultSrc = 2'b10;
        bus.PCUpdate = 1'b1;
        state_d = JALRLINK;
      end
      JALRLINK: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        state_d = ALUWB;
      end
`ifdef MCFSM_UIMM_EN
      LUI: begin
        bus.ALUSrcA = 2'b11;
        bus.ALUSrcB = 2'b01;
        state_d = ALUWB;
      end
      AUIPC: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        state_d = ALUWB;
      end
`endif
      default: ;
    endcase
    // A completing access always wins over an expiring wait budget
    if (MEM_TIMEOUT != 0 && mem_wait && wait_q == WMAX) begin
      state_d = TRAP;
      timeout_d = 1'b1;
    end
    wait_d = state_d != state_q ? '0 : mem_wait && wait_q != WMAX ? wait_q + 1'b1 : wait_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      wait_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end
endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb_multicycle_main_fsm: directed scenarios plus randomized run against an instruction-step model.
module tb_multicycle_main_fsm;
  localparam logic [4:0] S_FETCH = 5'd0, S_DECODE = 5'd1, S_MEMADR = 5'd2, S_MEMREAD = 5'd3,
    S_MEMWB = 5'd4, S_MEMWRITE = 5'd5, S_EXECR = 5'd6, S_EXECI = 5'd7, S_ALUWB = 5'd8,
    S_BEQ = 5'd9, S_JAL = 5'd10, S_JALR = 5'd11, S_JALRLINK = 5'd12, S_LUI = 5'd13,
    S_AUIPC = 5'd14, S_TRAP = 5'd15;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
    OP_I = 7'b0010011, OP_B = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
    OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
`ifdef MCFSM_UIMM_EN
  localparam bit UIMM = 1'b1;
`else
  localparam bit UIMM = 1'b0;
`endif
  typedef logic [4:0] seq_t[$];
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_fail = 0;
  multicycle_main_fsm_if b4 ();
  multicycle_main_fsm_if b0 ();
  multicycle_main_fsm #(.MEM_TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(b4));
  multicycle_main_fsm #(.MEM_TIMEOUT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  always #5 clk = ~clk;
  logic [13:0] ctl4;
  assign ctl4 = {b4.PCUpdate, b4.Branch, b4.AdrSrc, b4.MemWrite, b4.IRWrite, b4.RegWrite,
                 b4.ResultSrc, b4.ALUSrcA, b4.ALUSrcB, b4.ALUOp};

  // Each instruction is a fixed list of steps; memory steps stretch while MemReady is low.
  function automatic seq_t seq_of(logic [6:0] op);
    seq_t q;
    case (op)
      OP_LW:   q = {S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB};
      OP_SW:   q = {S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE};
      OP_R:    q = {S_FETCH, S_DECODE, S_EXECR, S_ALUWB};
      OP_I:    q = {S_FETCH, S_DECODE, S_EXECI, S_ALUWB};
      OP_B:    q = {S_FETCH, S_DECODE, S_BEQ};
      OP_JAL:  q = {S_FETCH, S_DECODE, S_JAL, S_ALUWB};
      OP_JALR: q = {S_FETCH, S_DECODE, S_JALR, S_JALRLINK, S_ALUWB};
      OP_LUI:   q = UIMM ? {S_FETCH, S_DECODE, S_LUI, S_ALUWB} : {S_FETCH, S_DECODE, S_TRAP};
      OP_AUIPC: q = UIMM ? {S_FETCH, S_DECODE, S_AUIPC, S_ALUWB} : {S_FETCH, S_DECODE, S_TRAP};
      default: q = {S_FETCH, S_DECODE, S_TRAP};
    endcase
    return q;
  endfunction

  // {PCUpdate,Branch,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}
  function automatic logic [13:0] ctl_of(logic [4:0] s, logic rdy);
    case (s)
      S_FETCH:    return {rdy, 3'b000, rdy, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00};
      S_DECODE:   return {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00};
      S_MEMADR:   return {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00};
      S_MEMREAD:  return {6'b001000, 8'b0};
      S_MEMWRITE: return {6'b001100, 8'b0};
      S_MEMWB:    return {6'b000001, 2'b01, 6'b0};
      S_EXECR:    return {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10};
      S_EXECI:    return {6'b000000, 2'b00, 2'b10, 2'b01, 2'b10};
      S_ALUWB:    return {6'b000001, 8'b0};
      S_BEQ:      return {6'b010000, 2'b00, 2'b10, 2'b00, 2'b01};
      S_JAL:      return {6'b100000, 2'b00, 2'b01, 2'b10, 2'b00};
      S_JALR:     return {6'b100000, 2'b10, 2'b10, 2'b01, 2'b00};
      S_JALRLINK: return {6'b000000, 2'b00, 2'b01, 2'b10, 2'b00};
      S_LUI:      return {6'b000000, 2'b00, 2'b11, 2'b01, 2'b00};
      S_AUIPC:    return {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00};
      default:    return 14'b0;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(logic [6:0] op);
    if (op == OP_SW) return 3'b001;
    if (op == OP_B) return 3'b010;
    if (op == OP_JAL) return 3'b011;
    if (UIMM && (op == OP_LUI || op == OP_AUIPC)) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [6:0] pick_op();
    case ($urandom_range(0, 9))
      0: return OP_LW;
      1: return OP_SW;
      2: return OP_R;
      3: return OP_I;
      4: return OP_B;
      5: return OP_JAL;
      6: return OP_JALR;
      7: return $urandom_range(0, 1) ? OP_LUI : OP_AUIPC;
      8: return OP_LW;
      default: return 7'($urandom_range(0, 127));
    endcase
  endfunction

  task automatic do_reset(logic [6:0] op, logic rdy);
    b4.Op = op;
    b4.MemReady = rdy;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    b4.Op = OP_R;
    b4.MemReady = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++; if (b4.State !== S_FETCH) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", b4.State, S_FETCH); end
    n_vec++; if (ctl4 !== ctl_of(S_FETCH, 1'b0)) begin n_fail++; $display("FAIL reset_ctl: got %h want %h", ctl4, ctl_of(S_FETCH, 1'b0)); end
    n_vec++; if ({b4.Illegal, b4.Timeout} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {b4.Illegal, b4.Timeout}); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if ({b4.IRWrite, b4.PCUpdate} !== 2'b11) begin n_fail++; $display("FAIL fetch_ready: got %b want 11", {b4.IRWrite, b4.PCUpdate}); end
  endtask

  task automatic test_rtype();
    logic [4:0] ex [5] = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB, S_FETCH};
    do_reset(OP_R, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++; if (b4.State !== ex[k]) begin n_fail++; $display("FAIL rtype_state[%0d]: got %0d want %0d", k, b4.State, ex[k]); end
      n_vec++; if (b4.RegWrite !== (k == 3)) begin n_fail++; $display("FAIL rtype_regwrite[%0d]: got %b want %b", k, b4.RegWrite, k == 3); end
      n_vec++; if (b4.ALUOp !== (k == 2 ? 2'b10 : 2'b00)) begin n_fail++; $display("FAIL rtype_aluop[%0d]: got %b", k, b4.ALUOp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_wait();
    logic [4:0] ex [7] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMREAD, S_MEMREAD, S_MEMWB};
    do_reset(OP_LW, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      b4.MemReady = !(k == 4 || k == 5);
      @(negedge clk);
      n_vec++; if (b4.State !== ex[k-1]) begin n_fail++; $display("FAIL load_state[%0d]: got %0d want %0d", k, b4.State, ex[k-1]); end
      n_vec++; if (b4.RegWrite !== (k == 7)) begin n_fail++; $display("FAIL load_regwrite[%0d]: got %b", k, b4.RegWrite); end
      n_vec++; if (b4.Timeout !== 1'b0) begin n_fail++; $display("FAIL load_timeout[%0d]: got %b want 0", k, b4.Timeout); end
      if (k == 7) begin
        n_vec++; if (b4.ResultSrc !== 2'b01) begin n_fail++; $display("FAIL load_resultsrc: got %b want 01", b4.ResultSrc); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [4:0] ex [3] = '{S_FETCH, S_DECODE, S_TRAP};
    do_reset(7'b0000000, 1'b1);
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      n_vec++; if (b4.State !== (k < 3 ? ex[k] : S_TRAP)) begin n_fail++; $display("FAIL illegal_state[%0d]: got %0d", k, b4.State); end
      if (k >= 2) begin
        n_vec++; if ({b4.Illegal, b4.Timeout} !== 2'b10) begin n_fail++; $display("FAIL illegal_flags[%0d]: got %b want 10", k, {b4.Illegal, b4.Timeout}); end
        n_vec++; if (ctl4 !== 14'b0) begin n_fail++; $display("FAIL illegal_strobes[%0d]: got %h want 0", k, ctl4); end
      end
      @(posedge clk);
      #1 b4.Op = 7'($urandom_range(0, 127));
      b4.MemReady = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_timeout();
    b0.Op = OP_R;
    b0.MemReady = 1'b0;
    do_reset(OP_R, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      n_vec++; if (b4.State !== (k <= 5 ? S_FETCH : S_TRAP)) begin n_fail++; $display("FAIL timeout_state[%0d]: got %0d", k, b4.State); end
      n_vec++; if (b4.IRWrite !== 1'b0) begin n_fail++; $display("FAIL timeout_irwrite[%0d]: got %b want 0", k, b4.IRWrite); end
      n_vec++; if ({b4.Illegal, b4.Timeout} !== (k <= 5 ? 2'b00 : 2'b01)) begin n_fail++; $display("FAIL timeout_flags[%0d]: got %b", k, {b4.Illegal, b4.Timeout}); end
      n_vec++; if ({b0.State, b0.Timeout} !== {S_FETCH, 1'b0}) begin n_fail++; $display("FAIL notimeout_hold[%0d]: got %0d/%b", k, b0.State, b0.Timeout); end
      @(posedge clk); #1;
    end
    b0.MemReady = 1'b1;
  endtask

  task automatic test_jalr();
    logic [4:0] ex [6] = '{S_FETCH, S_DECODE, S_JALR, S_JALRLINK, S_ALUWB, S_FETCH};
    do_reset(OP_JALR, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_vec++; if (b4.State !== ex[k]) begin n_fail++; $display("FAIL jalr_state[%0d]: got %0d want %0d", k, b4.State, ex[k]); end
      n_vec++; if (b4.RegWrite !== (k == 4)) begin n_fail++; $display("FAIL jalr_regwrite[%0d]: got %b", k, b4.RegWrite); end
      if (k == 2) begin
        n_vec++; if ({b4.PCUpdate, b4.ResultSrc} !== 3'b110) begin n_fail++; $display("FAIL jalr_pc: got %b want 110", {b4.PCUpdate, b4.ResultSrc}); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_uimm();
    do_reset(OP_LUI, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++; if (b4.ImmSrc !== (UIMM ? 3'b100 : 3'b000)) begin n_fail++; $display("FAIL lui_imm[%0d]: got %b", k, b4.ImmSrc); end
      if (k == 2) begin
        n_vec++; if (b4.State !== (UIMM ? S_LUI : S_TRAP)) begin n_fail++; $display("FAIL lui_state: got %0d", b4.State); end
        n_vec++; if (b4.ALUSrcA !== (UIMM ? 2'b11 : 2'b00)) begin n_fail++; $display("FAIL lui_srca: got %b", b4.ALUSrcA); end
        n_vec++; if (b4.Illegal !== !UIMM) begin n_fail++; $display("FAIL lui_illegal: got %b want %b", b4.Illegal, !UIMM); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_reset();
    do_reset(OP_SW, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      b4.MemReady = k < 4;
      @(negedge clk);
      if (k == 5) begin
        n_vec++; if ({b4.State, b4.MemWrite} !== {S_MEMWRITE, 1'b1}) begin n_fail++; $display("FAIL store_wait: got %0d/%b", b4.State, b4.MemWrite); end
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if ({b4.State, b4.MemWrite, b4.RegWrite} !== {S_FETCH, 2'b00}) begin n_fail++; $display("FAIL store_abort: got %0d/%b/%b", b4.State, b4.MemWrite, b4.RegWrite); end
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random(int ncyc);
    seq_t sq;
    int pos = 0, wcnt = 0, tcyc = 0;
    bit trap = 0, ill = 0, to = 0;
    logic [4:0] es;
    logic [6:0] op = pick_op();
    sq = seq_of(op);
    do_reset(op, 1'b1);
    for (int c = 0; c < ncyc; c++) begin
      b4.MemReady = $urandom_range(0, 99) < 65;
      es = trap ? S_TRAP : sq[pos];
      @(negedge clk);
      n_vec++; if (b4.State !== es) begin n_fail++; $display("FAIL rnd_state[%0d]: got %0d want %0d op %b", c, b4.State, es, op); end
      n_vec++; if (ctl4 !== ctl_of(es, b4.MemReady)) begin n_fail++; $display("FAIL rnd_ctl[%0d]: got %h want %h", c, ctl4, ctl_of(es, b4.MemReady)); end
      n_vec++; if (b4.ImmSrc !== imm_of(op)) begin n_fail++; $display("FAIL rnd_imm[%0d]: got %b want %b", c, b4.ImmSrc, imm_of(op)); end
      n_vec++; if ({b4.Illegal, b4.Timeout} !== {ill, to}) begin n_fail++; $display("FAIL rnd_flags[%0d]: got %b want %b", c, {b4.Illegal, b4.Timeout}, {ill, to}); end
      @(posedge clk); #1;
      if (trap) tcyc++;
      else if ((es == S_FETCH || es == S_MEMREAD || es == S_MEMWRITE) && !b4.MemReady) begin
        if (wcnt == 4) begin trap = 1; to = 1; end
        else wcnt++;
      end else begin
        wcnt = 0;
        pos++;
        if (pos == sq.size()) begin
          pos = 0; op = pick_op(); sq = seq_of(op); b4.Op = op;
        end else if (sq[pos] == S_TRAP) begin
          trap = 1; ill = 1;
        end
      end
      if (tcyc > 3 || $urandom_range(0, 99) < 2) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        pos = 0; wcnt = 0; tcyc = 0; trap = 0; ill = 0; to = 0;
        op = pick_op(); sq = seq_of(op); b4.Op = op;
      end
    end
  endtask

  initial begin
    b0.Op = OP_R;
    b0.MemReady = 1'b1;
    test_reset();
    test_rtype();
    test_load_wait();
    test_illegal();
    test_timeout();
    test_jalr();
    test_uimm();
    test_store_reset();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_main_fsm.md
# multicycle_main_fsm

Main control state machine for the multi-cycle RV32I core, replacing the single-cycle main decoder. Sequences each instruction through fetch, decode, execute, memory and write-back steps, driving the datapath mux selects and write enables one state at a time. It waits on a memory ready handshake with a bounded timeout, and traps on unsupported opcodes. It sits between the instruction register opcode field and the shared-memory datapath.

## Interface
- MEM_TIMEOUT, 16, maximum consecutive wait cycles tolerated in any memory state; 0 disables the timeout
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- Op  in  7  opcode from the instruction register
- MemReady  in  1  memory completes the current access this cycle
- PCUpdate  out  1  PC write request (unconditional)
- Branch  out  1  conditional PC write request, qualified by the branch comparator outside this block
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data store strobe
- IRWrite  out  1  instruction register and OldPC load
- RegWrite  out  1  register file write
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  A select: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
- ALUSrcB  out  2  B select: 00 = rs2, 01 = ImmExt, 10 = constant 4
- ALUOp  out  2  ALU decoder mode: 00 = add, 01 = branch compare, 10 = funct-decoded
- ImmSrc  out  3  immediate format from Op: I=000, S=001, B=010, J=011, U=100, other=000
- Illegal  out  1  sticky trap flag for an unsupported opcode
- Timeout  out  1  sticky trap flag for a memory wait timeout
- State  out  5  current state encoding, for debug

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, JALR, JALRLINK, LUI, AUIPC, TRAP.
- Every output not listed for a state is 0.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate assert only when MemReady=1. Goes to DECODE on MemReady, otherwise holds.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target). Next state by Op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - anything else → TRAP, with Illegal set
- MEMADR: ALUSrcA=10, ALUSrcB=01. Goes to MEMREAD if Op=0000011, otherwise MEMWRITE.
- MEMREAD: AdrSrc=1. Goes to MEMWB on MemReady.
- MEMWRITE: AdrSrc=1. MemWrite is asserted every cycle until MemReady, and the memory ignores repeats. Goes to FETCH on MemReady.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 → FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCUpdate=1 → ALUWB.
- JALR: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, PCUpdate=1 → JALRLINK.
- JALRLINK: ALUSrcA=01, ALUSrcB=10 → ALUWB.
- LUI: ALUSrcA=11, ALUSrcB=01 → ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01 → ALUWB.
- TRAP: all strobes 0. Absorbing; only reset exits.
- Wait counter:
  - Increments each cycle spent in FETCH, MEMREAD or MEMWRITE with MemReady=0.
  - Clears on any state change.
  - When it reaches MEM_TIMEOUT with MemReady still 0, the next state is TRAP and Timeout is set.
  - MemReady=1 in that same cycle wins: the access completes normally.
  - The counter saturates and never wraps.
- Illegal and Timeout are mutually exclusive; whichever trap is entered first is the only flag set.

## Timing
- Reset (asynchronous assert, synchronous release): State=FETCH, wait counter=0, Illegal=0, Timeout=0.
- Outputs during reset are the FETCH decode with MemReady gating; IRWrite and PCUpdate stay 0 while rst_n=0.
- Outputs are combinational from the state register, plus MemReady gating in FETCH only. Transitions occur on the rising clk edge.
- Latency with zero wait states, FETCH through last state inclusive:
  - load 5
  - store 4
  - R/I-type 4
  - branch 3
  - JAL 4
  - JALR 5
  - LUI/AUIPC 4
- Each wait cycle adds 1.
- Reset asserted mid-instruction aborts it immediately. No partial write-back occurs after rst_n falls.
- ImmSrc is decoded from Op in every state.

## Configuration
- MCFSM_UIMM_EN defined: LUI and AUIPC states exist and decode as above.
- MCFSM_UIMM_EN undefined:
  - Op 0110111 and 0010111 go DECODE→TRAP with Illegal=1.
  - ImmSrc returns 000 for those opcodes.
  - The LUI and AUIPC states are not built.

## Test plan
- Reset, then Op=0110011 with MemReady=1: states FETCH, DECODE, EXECR, ALUWB, FETCH. RegWrite=1 only in cycle 4. ALUOp=10 in cycle 3.
- Op=0000011 with MemReady low for 2 cycles in MEMREAD: MEMWB is entered 7 cycles after FETCH. ResultSrc=01 and RegWrite=1 in MEMWB. Timeout=0.
- Op=0000000: DECODE→TRAP. Illegal=1 and stays 1 for 10 further cycles regardless of Op. All strobes 0.
- MemReady held 0 in FETCH with MEM_TIMEOUT=4: TRAP after 5 cycles with Timeout=1 and IRWrite never asserted. Repeat with MEM_TIMEOUT=0: FETCH holds indefinitely.
- Op=1100111 with MemReady=1: PCUpdate=1 with ResultSrc=10 in JALR, then JALRLINK, then RegWrite=1 in ALUWB.
- Op=0110111 with the macro defined: LUI with ALUSrcA=11, ImmSrc=100. Without the macro: TRAP with Illegal=1. Separately, rst_n pulsed low mid-MEMWRITE: MemWrite drops immediately and State=FETCH.
